debug_trace_buffer: RTL and testbench
=====================================

// Module: debug_trace_buffer
// PURPOSE
//  Retire-side consumer of the debug tick/instruction chain (ID/EX -> EX/MEM -> MEM/WB -> here).
//  Captures each retired (tick, inst) pair into a FIFO trace buffer.
//  A debug host drains the buffer through a valid/ready port.
//  Bubbles (inst == 0, as written by pipeline flush/reset) are never captured.
// PARAMETERS
//  DEPTH       16  trace entries; power of two, >= 2
//  DROP_WIDTH  16  width of saturating dropped-entry counter
// PORTS
//  i_clock          in   1          clock
//  i_reset          in   1          one clock; reset is asynchronous and active-low
//  i_stall          in   1          retire stage stalled; input pair not new, no capture
//  i_enable         in   1          host capture enable
//  i_dbgTick        in   32 (int)   tick of retiring instruction
//  i_dbgInst        in   32 (Inst)  retiring instruction; 0 = bubble
//  i_rdReady        in   1          host accepts head entry
//  o_rdValid        out  1          head entry valid (= !empty)
//  o_rdTick         out  32         head entry tick
//  o_rdInst         out  32         head entry instruction
//  o_count          out  clog2(DEPTH)+1  occupancy
//  o_full           out  1          count == DEPTH
//  o_dropCount      out  DROP_WIDTH entries lost to full buffer, saturating
//  o_state          out  TraceState current capture state
// BEHAVIOUR
//  Reset (async assert, sync release): pointers/count 0, o_rdValid 0, o_rdTick/o_rdInst 0,
//   o_dropCount 0, state IDLE; reset mid-operation discards all contents.
//  FSM: IDLE -> RUN when i_enable=1; RUN -> IDLE when i_enable=0 (contents kept, still drainable).
//  capture = (state==RUN) & !i_stall & (i_dbgInst != 0).
//  push: capture & (!full | pop). pop: o_rdValid & i_rdReady.
//  Full + capture + pop same cycle: both occur, count unchanged.
//  Full + capture, no pop: entry dropped, o_dropCount += 1, saturates at all-ones.
//  Empty: pop impossible (o_rdValid=0); push on empty -> o_rdValid high next cycle, no bypass.
//  Latency: captured in cycle N, visible at head in cycle N+1. First-word-fall-through read.
//  Pointers wrap modulo DEPTH; count never exceeds DEPTH.
// CONFIGURATION
//  DEBUG_TRACE_TRIGGER_EN defined:
//   adds ports i_trigMask, i_trigMatch (32 each), i_postCount (clog2(DEPTH)+1).
//   FSM: IDLE -> ARMED on i_enable.
//   ARMED -> RUN on a capturable inst with (inst & mask) == match; that inst is captured.
//   RUN -> DONE after i_postCount captures including the trigger; DONE freezes capture.
//   any state -> IDLE on !i_enable.
//  Undefined: no extra ports, states ARMED/DONE unused; capture per base FSM only.
// STRUCTURE
//  CoreDefs additions: TraceEntry struct {int tick; Inst inst;}, TraceState enum
//   {TS_IDLE, TS_ARMED, TS_RUN, TS_DONE}.
//  Sub-module trace_fifo: DEPTH x TraceEntry storage, push/pop, count, full/empty.
//  Top module holds FSM, capture qualification, drop counter, trigger logic.
// TESTING
//  1 enable, retire ticks 1..3 inst 0x00000013 -> 3 entries, read out in order, tick 1,2,3.
//  2 inst=0 and i_stall=1 cycles interleaved -> no entries captured, o_count unchanged.
//  3 DEPTH=16, push 18 with i_rdReady=0 -> o_full=1, o_dropCount=2; push+pop while full -> count stays 16.
//  4 drop counter DROP_WIDTH=4, 20 drops -> o_dropCount holds 15.
//  5 i_reset low with 5 entries -> o_count=0, o_rdValid=0, state IDLE, asynchronously.
//  6 [TRIGGER_EN] mask 0x7F match 0x63, postCount 3 -> capture starts at first branch, 3 entries, DONE.

Source files
------------

// File: rtl/debug_trace_buffer_pkg.sv
// Shared types for the retire-side debug trace buffer.
// The optional trigger feature is enabled with the DEBUG_TRACE_TRIGGER_EN macro.
package debug_trace_buffer_pkg;

   typedef logic [31:0] Inst;

   typedef struct packed {
      logic [31:0] tick;
      Inst         inst;
   } TraceEntry;

   typedef enum logic [1:0] {
      TS_IDLE  = 2'd0,
      TS_ARMED = 2'd1,
      TS_RUN   = 2'd2,
      TS_DONE  = 2'd3
   } TraceState;

   localparam Inst BUBBLE_INST = 32'h0000_0000;

endpackage

// File: rtl/debug_trace_buffer_fifo.sv
// First-word-fall-through FIFO holding DEPTH trace entries.
// A push while full is accepted only when a pop happens in the same cycle,
// and the head reads as zero whenever the FIFO is empty.
module trace_fifo
   import debug_trace_buffer_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  TraceEntry                i_data,
   output TraceEntry                o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);

   TraceEntry      mem [DEPTH];
   logic [AW-1:0]  wrPtr;
   logic [AW-1:0]  rdPtr;
   logic [AW:0]    count;
   logic           pushOk;
   logic           popOk;

   assign o_full  = (count == (AW+1)'(DEPTH));
   assign o_empty = (count == '0);
   assign popOk   = i_pop & ~o_empty;
   assign pushOk  = i_push & (~o_full | popOk);

   // Storage is written without reset; stale contents are hidden behind the empty gate.
   always_ff @(posedge i_clock) begin
      if (pushOk) begin
         mem[wrPtr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (pushOk) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (popOk) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({pushOk, popOk})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign o_data  = o_empty ? '0 : mem[rdPtr];
   assign o_count = count;

endmodule

// File: rtl/debug_trace_buffer.sv
// Retire-side trace capture: qualifies retiring (tick, inst) pairs, stores them
// in a FIFO the debug host drains through a valid/ready port, and counts
// entries lost to a full buffer.
// Optional trigger/post-count capture window: define DEBUG_TRACE_TRIGGER_EN.
module debug_trace_buffer
   import debug_trace_buffer_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int DROP_WIDTH = 16
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   input  logic                     i_stall,
   input  logic                     i_enable,
   input  logic [31:0]              i_dbgTick,
   input  logic [31:0]              i_dbgInst,
   input  logic                     i_rdReady,
`ifdef DEBUG_TRACE_TRIGGER_EN
   input  logic [31:0]              i_trigMask,
   input  logic [31:0]              i_trigMatch,
   input  logic [$clog2(DEPTH):0]   i_postCount,
`endif
   output logic                     o_rdValid,
   output logic [31:0]              o_rdTick,
   output logic [31:0]              o_rdInst,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic [DROP_WIDTH-1:0]    o_dropCount,
   output TraceState                o_state
);

   localparam int CW = $clog2(DEPTH) + 1;

   TraceState             state;
   TraceState             nextState;
   TraceEntry             pushEntry;
   TraceEntry             headEntry;
   logic                  capturable;
   logic                  capture;
   logic                  push;
   logic                  pop;
   logic                  drop;
   logic                  empty;
   logic                  full;
   logic [DROP_WIDTH-1:0] dropCount;

   assign capturable = ~i_stall & (i_dbgInst != BUBBLE_INST);

`ifdef DEBUG_TRACE_TRIGGER_EN
   logic          trigHit;
   logic [CW-1:0] postLeft;

   assign trigHit = (state == TS_ARMED) & capturable &
                    ((i_dbgInst & i_trigMask) == i_trigMatch);
   assign capture = trigHit | ((state == TS_RUN) & capturable);

   // Trigger-mode sequencing: arm on enable, open the window on a match,
   // close it after the requested number of captures, drop to idle on disable.
   always_comb begin
      nextState = state;
      if (!i_enable) begin
         nextState = TS_IDLE;
      end else begin
         case (state)
            TS_IDLE:  nextState = TS_ARMED;
            TS_ARMED: begin
               if (trigHit) begin
                  nextState = (i_postCount <= CW'(1)) ? TS_DONE : TS_RUN;
               end
            end
            TS_RUN: begin
               if (capture && postLeft <= CW'(1)) begin
                  nextState = TS_DONE;
               end
            end
            default:  nextState = state;
         endcase
      end
   end

   // Remaining captures in the post-trigger window, counting the trigger itself.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         postLeft <= '0;
      end else if (trigHit) begin
         postLeft <= (i_postCount == '0) ? '0 : i_postCount - 1'b1;
      end else if (state == TS_RUN && capture && postLeft != '0) begin
         postLeft <= postLeft - 1'b1;
      end
   end
`else
   assign capture = (state == TS_RUN) & capturable;

   // Base sequencing: capture runs while the host enable is high; disabling keeps contents.
   always_comb begin
      nextState = state;
      case (state)
         TS_IDLE: if (i_enable)  nextState = TS_RUN;
         TS_RUN:  if (!i_enable) nextState = TS_IDLE;
         default: nextState = TS_IDLE;
      endcase
   end
`endif

   // Capture-state register.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state <= TS_IDLE;
      end else begin
         state <= nextState;
      end
   end

   assign pop       = ~empty & i_rdReady;
   assign push      = capture & (~full | pop);
   assign drop      = capture & full & ~pop;
   assign pushEntry = '{tick: i_dbgTick, inst: i_dbgInst};

   // Saturating count of entries lost because the host did not drain in time.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         dropCount <= '0;
      end else if (drop && dropCount != '1) begin
         dropCount <= dropCount + 1'b1;
      end
   end

   trace_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_push  (push),
      .i_pop   (pop),
      .i_data  (pushEntry),
      .o_data  (headEntry),
      .o_count (o_count),
      .o_full  (full),
      .o_empty (empty)
   );

   assign o_rdValid   = ~empty;
   assign o_rdTick    = headEntry.tick;
   assign o_rdInst    = headEntry.inst;
   assign o_full      = full;
   assign o_dropCount = dropCount;
   assign o_state     = state;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed self-checking bench for debug_trace_buffer (DEPTH=16, DROP_WIDTH=4).
// Trigger scenario compiles only with DEBUG_TRACE_TRIGGER_EN defined.
module tb_debug_trace_buffer;
   import debug_trace_buffer_pkg::*;

   localparam int DEPTH      = 16;
   localparam int DROP_WIDTH = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic                  i_clock;
   logic                  i_reset;
   logic                  i_stall;
   logic                  i_enable;
   logic [31:0]           i_dbgTick;
   logic [31:0]           i_dbgInst;
   logic                  i_rdReady;
`ifdef DEBUG_TRACE_TRIGGER_EN
   logic [31:0]           i_trigMask;
   logic [31:0]           i_trigMatch;
   logic [4:0]            i_postCount;
`endif
   logic                  o_rdValid;
   logic [31:0]           o_rdTick;
   logic [31:0]           o_rdInst;
   logic [4:0]            o_count;
   logic                  o_full;
   logic [DROP_WIDTH-1:0] o_dropCount;
   TraceState             o_state;

   int errors = 0;
   int checks = 0;

   debug_trace_buffer #(
      .DEPTH      (DEPTH),
      .DROP_WIDTH (DROP_WIDTH)
   ) dut (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_stall     (i_stall),
      .i_enable    (i_enable),
      .i_dbgTick   (i_dbgTick),
      .i_dbgInst   (i_dbgInst),
      .i_rdReady   (i_rdReady),
`ifdef DEBUG_TRACE_TRIGGER_EN
      .i_trigMask  (i_trigMask),
      .i_trigMatch (i_trigMatch),
      .i_postCount (i_postCount),
`endif
      .o_rdValid   (o_rdValid),
      .o_rdTick    (o_rdTick),
      .o_rdInst    (o_rdInst),
      .o_count     (o_count),
      .o_full      (o_full),
      .o_dropCount (o_dropCount),
      .o_state     (o_state)
   );

   // Free-running 10 ns clock.
   initial begin
      i_clock = 1'b0;
      forever #5 i_clock = ~i_clock;
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge i_clock);
      #1;
   endtask

   // Present one retire-stage pair for a single cycle.
   task automatic applyStimulus(input logic [31:0] tick, input logic [31:0] inst,
                                input logic stall, input logic rdReady);
      i_dbgTick = tick;
      i_dbgInst = inst;
      i_stall   = stall;
      i_rdReady = rdReady;
      step();
   endtask

   // Stimulus and checks.
   initial begin
      i_reset   = 1'b0;
      i_stall   = 1'b0;
      i_enable  = 1'b0;
      i_dbgTick = '0;
      i_dbgInst = '0;
      i_rdReady = 1'b0;
`ifdef DEBUG_TRACE_TRIGGER_EN
      i_trigMask  = '0;
      i_trigMatch = '0;
      i_postCount = '0;
`endif
      step();
      step();
      checkOutput("rst_count",  64'(o_count),     64'd0);
      checkOutput("rst_valid",  64'(o_rdValid),   64'd0);
      checkOutput("rst_tick",   64'(o_rdTick),    64'd0);
      checkOutput("rst_drop",   64'(o_dropCount), 64'd0);
      checkOutput("rst_state",  64'(o_state),     64'(TS_IDLE));
      i_reset = 1'b1;
      step();

`ifndef DEBUG_TRACE_TRIGGER_EN
      i_enable = 1'b1;
      step();
      checkOutput("en_state", 64'(o_state), 64'(TS_RUN));

      applyStimulus(32'd1, NOP, 1'b0, 1'b0);
      checkOutput("t1_latency_valid", 64'(o_rdValid), 64'd1);
      checkOutput("t1_latency_count", 64'(o_count),   64'd1);
      applyStimulus(32'd2, NOP, 1'b0, 1'b0);
      applyStimulus(32'd3, NOP, 1'b0, 1'b0);
      i_dbgInst = '0;
      checkOutput("t1_count3", 64'(o_count),  64'd3);
      checkOutput("t1_head1",  64'(o_rdTick), 64'd1);
      checkOutput("t1_inst1",  64'(o_rdInst), 64'(NOP));
      applyStimulus(32'd0, 32'd0, 1'b0, 1'b1);
      checkOutput("t1_head2",  64'(o_rdTick), 64'd2);
      applyStimulus(32'd0, 32'd0, 1'b0, 1'b1);
      checkOutput("t1_head3",  64'(o_rdTick), 64'd3);
      applyStimulus(32'd0, 32'd0, 1'b0, 1'b1);
      checkOutput("t1_empty_valid", 64'(o_rdValid), 64'd0);
      checkOutput("t1_empty_tick",  64'(o_rdTick),  64'd0);

      applyStimulus(32'd10, NOP,   1'b1, 1'b0);
      applyStimulus(32'd11, 32'd0, 1'b0, 1'b0);
      applyStimulus(32'd12, 32'd0, 1'b1, 1'b0);
      checkOutput("t2_none", 64'(o_count), 64'd0);
      applyStimulus(32'd13, NOP,   1'b0, 1'b0);
      applyStimulus(32'd14, NOP,   1'b1, 1'b0);
      applyStimulus(32'd15, 32'd0, 1'b0, 1'b0);
      checkOutput("t2_one",  64'(o_count),  64'd1);
      checkOutput("t2_head", 64'(o_rdTick), 64'd13);
      applyStimulus(32'd0, 32'd0, 1'b0, 1'b1);
      checkOutput("t2_drained", 64'(o_count), 64'd0);

      for (int k = 0; k < 18; k++) begin
         applyStimulus(32'd100 + 32'(k), NOP, 1'b0, 1'b0);
      end
      checkOutput("t3_count", 64'(o_count),     64'd16);
      checkOutput("t3_full",  64'(o_full),      64'd1);
      checkOutput("t3_drop",  64'(o_dropCount), 64'd2);
      checkOutput("t3_head",  64'(o_rdTick),    64'd100);
      applyStimulus(32'd200, NOP, 1'b0, 1'b1);
      checkOutput("t3_pp_count", 64'(o_count),     64'd16);
      checkOutput("t3_pp_drop",  64'(o_dropCount), 64'd2);
      checkOutput("t3_pp_head",  64'(o_rdTick),    64'd101);

      for (int k = 0; k < 13; k++) begin
         applyStimulus(32'd300 + 32'(k), NOP, 1'b0, 1'b0);
      end
      checkOutput("t4_drop_max", 64'(o_dropCount), 64'd15);
      for (int k = 0; k < 7; k++) begin
         applyStimulus(32'd400 + 32'(k), NOP, 1'b0, 1'b0);
      end
      checkOutput("t4_drop_sat", 64'(o_dropCount), 64'd15);
      checkOutput("t4_head",     64'(o_rdTick),    64'd101);

      i_enable = 1'b0;
      applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("idle_state", 64'(o_state), 64'(TS_IDLE));
      applyStimulus(32'd500, NOP, 1'b0, 1'b1);
      checkOutput("idle_no_capture", 64'(o_count), 64'd15);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(32'd0, 32'd0, 1'b0, 1'b1);
      end
      i_rdReady = 1'b0;
      checkOutput("drain_count", 64'(o_count),  64'd5);
      checkOutput("drain_head",  64'(o_rdTick), 64'd112);

      i_enable = 1'b1;
      applyStimulus(32'd0, 32'd0, 1'b0, 1'b0);
      checkOutput("pre_rst_state", 64'(o_state), 64'(TS_RUN));
      i_reset = 1'b0;
      #1;
      checkOutput("t5_count", 64'(o_count),     64'd0);
      checkOutput("t5_valid", 64'(o_rdValid),   64'd0);
      checkOutput("t5_state", 64'(o_state),     64'(TS_IDLE));
      checkOutput("t5_drop",  64'(o_dropCount), 64'd0);
      step();
      i_reset  = 1'b1;
      i_enable = 1'b0;
      step();
`else
      i_trigMask  = 32'h0000_007F;
      i_trigMatch = 32'h0000_0063;
      i_postCount = 5'd3;
      i_enable    = 1'b1;
      step();
      checkOutput("tr_armed", 64'(o_state), 64'(TS_ARMED));
      applyStimulus(32'd1, NOP, 1'b0, 1'b0);
      checkOutput("tr_pre_count", 64'(o_count), 64'd0);
      applyStimulus(32'd2, 32'h0000_0463, 1'b0, 1'b0);
      checkOutput("tr_hit_count", 64'(o_count), 64'd1);
      checkOutput("tr_hit_state", 64'(o_state), 64'(TS_RUN));
      applyStimulus(32'd3, NOP, 1'b0, 1'b0);
      applyStimulus(32'd4, NOP, 1'b0, 1'b0);
      checkOutput("tr_done_state", 64'(o_state), 64'(TS_DONE));
      applyStimulus(32'd5, NOP, 1'b0, 1'b0);
      applyStimulus(32'd6, 32'h0000_0063, 1'b0, 1'b0);
      checkOutput("tr_done_count", 64'(o_count),  64'd3);
      checkOutput("tr_head",       64'(o_rdTick), 64'd2);
      i_enable = 1'b0;
      step();
      checkOutput("tr_idle", 64'(o_state), 64'(TS_IDLE));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
